// File: rtl/pipe_hazard_ctrl_if.sv
// Purpose : hazard-controller bundle: ID/EX/MEM decode fields in, stall/flush controls out.
// Latency : pure wires; the controller drives the outputs combinationally from these inputs.
// Backpres: none; ext_stall is carried here as the front-end freeze request.
// Ports   : master = pipeline datapath side, slave = pipe_hazard_ctrl side.
interface pipe_hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
);
  // ID stage
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic              id_is_branch;
  logic              id_is_jump;
  logic              branch_taken;
  // EX stage
  logic              ex_mem_read;
  logic              ex_reg_write;
  logic [REG_AW-1:0] ex_rd;
  // MEM stage
  logic              mem_mem_read;
  logic [REG_AW-1:0] mem_rd;
  // memory-system wait
  logic              ext_stall;
  // controls back to the pipeline
  logic              hazard;
  logic              branch_bubble;
  logic              idex_bubble;
  logic              if_flush;
  logic              pc_write;
  logic [PERF_W-1:0] stall_cycles;
  logic [PERF_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_is_jump, branch_taken,
    output ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd, ext_stall,
    input  hazard, branch_bubble, idex_bubble, if_flush, pc_write, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, id_is_branch, id_is_jump, branch_taken,
    input  ex_mem_read, ex_reg_write, ex_rd, mem_mem_read, mem_rd, ext_stall,
    output hazard, branch_bubble, idex_bubble, if_flush, pc_write, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush controller for the 5-stage pipeline (load-use hold, branch operand
//           wait bubbles, taken-branch/jump flush, PC write-enable, ID/EX bubble).
// Latency : all controls are combinational from the current inputs and the RUN/BWAIT state.
// Backpres: ext_stall overrides everything: front end held, FSM and countdown frozen.
// Ports   : clk, rst (synchronous, active-high); bus = pipe_hazard_ctrl_if.slave.
// Option  : define HAZ_PERF_CNT_EN to build the saturating stall_cycles/flush_count
//           counters; otherwise both outputs are tied to zero and no counter flops exist.
module pipe_hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MAX_BUB = 2,
  parameter int PERF_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_BUB + 1);
  localparam logic [CNT_W-1:0] NEED_ONE = CNT_W'(1);
  // A load in EX needs two cycles before its data can be compared in ID; clamp to MAX_BUB
  // so the countdown can never exceed MAX_BUB-1.
  localparam logic [CNT_W-1:0] NEED_LD  = CNT_W'((MAX_BUB < 2) ? MAX_BUB : 2);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    BWAIT = 2'd1
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] bcnt, bcnt_n;

  logic             hazard_c, bbub_c, idexb_c, flush_c;
  logic             m_ex, m_mem, load_use;
  logic [CNT_W-1:0] need;

  // Register zero is never a real dependency, and an unused source field is ignored.
  function automatic logic reg_match(input logic [REG_AW-1:0] src,
                                     input logic              uses,
                                     input logic [REG_AW-1:0] dst);
    return uses && (src != '0) && (src == dst);
  endfunction

  assign m_ex  = reg_match(bus.id_rs, bus.id_uses_rs, bus.ex_rd) ||
                 reg_match(bus.id_rt, bus.id_uses_rt, bus.ex_rd);
  assign m_mem = reg_match(bus.id_rs, bus.id_uses_rs, bus.mem_rd) ||
                 reg_match(bus.id_rt, bus.id_uses_rt, bus.mem_rd);

  // Branches are excluded: they consume operands in ID and get the longer branch wait.
  assign load_use = bus.ex_mem_read && m_ex && !bus.id_is_branch;

  // Cycles a branch in ID must wait for its operands to become forwardable into ID.
  always_comb begin
    need = '0;
    if (bus.ex_mem_read && m_ex) begin
      need = NEED_LD;
    end else if ((bus.ex_reg_write && m_ex) || (bus.mem_mem_read && m_mem)) begin
      need = NEED_ONE;
    end
  end

  always_comb begin
    state_n  = state;
    bcnt_n   = bcnt;
    hazard_c = 1'b0;
    bbub_c   = 1'b0;
    idexb_c  = 1'b0;
    flush_c  = 1'b0;
    if (bus.ext_stall) begin
      // Whole front end frozen; ID/EX keeps flowing so the memory op can complete.
      hazard_c = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (load_use) begin
            hazard_c = 1'b1;
            idexb_c  = 1'b1;
          end else if (bus.id_is_branch && (need != '0)) begin
            bbub_c  = 1'b1;
            idexb_c = 1'b1;
            // A single-cycle wait stays in RUN and simply re-evaluates next cycle.
            if (need > NEED_ONE) begin
              state_n = BWAIT;
              bcnt_n  = need - NEED_ONE;
            end
          end else begin
            flush_c = (bus.id_is_branch && bus.branch_taken) || bus.id_is_jump;
          end
        end
        BWAIT: begin
          // Inputs are deliberately not looked at: the wait length was fixed on entry.
          bbub_c  = 1'b1;
          idexb_c = 1'b1;
          if (bcnt <= NEED_ONE) begin
            state_n = RUN;
            bcnt_n  = '0;
          end else begin
            bcnt_n = bcnt - NEED_ONE;
          end
        end
        default: begin
          state_n = RUN;
          bcnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      bcnt  <= bcnt_n;
    end
  end

  assign bus.hazard        = hazard_c;
  assign bus.branch_bubble = bbub_c;
  assign bus.idex_bubble   = idexb_c;
  assign bus.if_flush      = flush_c;
  assign bus.pc_write      = !(hazard_c || bbub_c);

`ifdef HAZ_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if ((hazard_c || bbub_c) && (stall_q != {PERF_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_c && (flush_q != {PERF_W{1'b1}})) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign bus.stall_cycles = stall_q;
  assign bus.flush_count  = flush_q;
`else
  assign bus.stall_cycles = {PERF_W{1'b0}};
  assign bus.flush_count  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if #(.REG_AW(5), .PERF_W(32)) bus ();

  pipe_hazard_ctrl #(.REG_AW(5), .MAX_BUB(2), .PERF_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       jmp;
    logic       tk;
    logic       exm;
    logic       exw;
    logic [4:0] exrd;
    logic       memm;
    logic [4:0] memrd;
    logic       exs;
  } in_t;

  // expected outputs packed as {hazard, branch_bubble, idex_bubble, if_flush, pc_write}
  typedef struct {
    string      name;
    in_t        in;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];

  int pass_cnt = 0;
  int total    = 0;

  // reference-model state: bubbles still owed to a branch in ID, and perf totals
  int          pend;
  logic [31:0] stall_m;
  logic [31:0] flush_m;

  function automatic in_t mk(input int rs, input int rt, input int urs, input int urt,
                             input int br, input int jmp, input int tk, input int exm,
                             input int exw, input int exrd, input int memm, input int memrd,
                             input int exs);
    in_t v;
    v.rs = 5'(rs);   v.rt = 5'(rt);
    v.urs = (urs != 0); v.urt = (urt != 0);
    v.br = (br != 0);   v.jmp = (jmp != 0); v.tk = (tk != 0);
    v.exm = (exm != 0); v.exw = (exw != 0); v.exrd = 5'(exrd);
    v.memm = (memm != 0); v.memrd = 5'(memrd);
    v.exs = (exs != 0);
    return v;
  endfunction

  function automatic void add(input string nm, input in_t v, input logic [4:0] e);
    vec_t t;
    t.name = nm;
    t.in   = v;
    t.exp  = e;
    tbl.push_back(t);
  endfunction

  task automatic check5(input string nm, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got hz/bb/ib/fl/pw=%b expected %b", nm, act, exp);
  endtask

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic drive(input in_t v);
    bus.id_rs        = v.rs;
    bus.id_rt        = v.rt;
    bus.id_uses_rs   = v.urs;
    bus.id_uses_rt   = v.urt;
    bus.id_is_branch = v.br;
    bus.id_is_jump   = v.jmp;
    bus.branch_taken = v.tk;
    bus.ex_mem_read  = v.exm;
    bus.ex_reg_write = v.exw;
    bus.ex_rd        = v.exrd;
    bus.mem_mem_read = v.memm;
    bus.mem_rd       = v.memrd;
    bus.ext_stall    = v.exs;
  endtask

  // One pipeline cycle: inputs applied on the falling edge, outputs sampled 1ns later,
  // state advances on the following rising edge.
  task automatic cyc(input in_t v, input logic r, output logic [4:0] o);
    @(negedge clk);
    drive(v);
    rst = r;
    #1;
    o = {bus.hazard, bus.branch_bubble, bus.idex_bubble, bus.if_flush, bus.pc_write};
  endtask

  function automatic bit hit(input logic [4:0] s, input logic u, input logic [4:0] d);
    return u && (s != 5'd0) && (s == d);
  endfunction

  // Spec-level model: a branch owes (cycles until its producer's value reaches ID) bubbles;
  // a load in EX is 2 cycles away, an ALU result in EX or a load in MEM is 1 cycle away.
  function automatic logic [4:0] ref_out(input in_t v, input int p, output int p_n);
    bit mex, mmem, hz, bb, ib, fl;
    int need;
    mex  = hit(v.rs, v.urs, v.exrd)  || hit(v.rt, v.urt, v.exrd);
    mmem = hit(v.rs, v.urs, v.memrd) || hit(v.rt, v.urt, v.memrd);
    need = 0;
    if (v.exm && mex) need = 2;
    else if ((v.exw && mex) || (v.memm && mmem)) need = 1;
    hz = 0; bb = 0; ib = 0; fl = 0; p_n = p;
    if (v.exs) begin
      hz = 1;
    end else if (p > 0) begin
      bb = 1; ib = 1; p_n = p - 1;
    end else if (v.exm && mex && !v.br) begin
      hz = 1; ib = 1;
    end else if (v.br && need > 0) begin
      bb = 1; ib = 1; p_n = need - 1;
    end else begin
      fl = (v.br && v.tk) || v.jmp;
    end
    return {hz, bb, ib, fl, !(hz || bb)};
  endfunction

  logic [4:0] o;
  logic [4:0] e;
  in_t        idle_v, bl_v, stall_v, tk_v, rv;
  int         p_n;
  logic       r;

  initial begin
    rst = 1'b1;
    idle_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bl_v    = mk(0, 8, 0, 1, 1, 0, 0, 1, 1, 8, 0, 0, 0); // branch reading r8, load to r8 in EX
    stall_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    tk_v    = mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0); // taken branch, no dependencies
    drive(idle_v);

    add("idle",            idle_v,                                          5'b00001);
    add("loaduse_rs",      mk(5, 0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0),       5'b10100);
    add("loaduse_r0",      mk(0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0),       5'b00001);
    add("loaduse_unused",  mk(5, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 0, 0),       5'b00001);
    add("loaduse_rt",      mk(0, 9, 0, 1, 0, 0, 0, 1, 1, 9, 0, 0, 0),       5'b10100);
    add("alu_dep_nobr",    mk(3, 0, 1, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0),       5'b00001);
    add("memld_dep_nobr",  mk(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 1, 7, 0),       5'b00001);
    add("br_alu_dep",      mk(3, 0, 1, 0, 1, 0, 1, 0, 1, 3, 0, 0, 0),       5'b01100);
    add("br_memld_dep",    mk(0, 7, 0, 1, 1, 0, 1, 0, 0, 0, 1, 7, 0),       5'b01100);
    add("br_taken_nodep",  mk(4, 6, 1, 1, 1, 0, 1, 0, 1, 2, 1, 3, 0),       5'b00011);
    add("br_not_taken",    mk(4, 6, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0),       5'b00001);
    add("jump",            mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0),       5'b00011);
    add("ext_stall_jump",  mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1),       5'b10000);
    add("jump_loaduse",    mk(5, 0, 1, 0, 0, 1, 0, 1, 1, 5, 0, 0, 0),       5'b10100);
    add("ext_stall_lu",    mk(5, 0, 1, 0, 0, 0, 0, 1, 1, 5, 0, 0, 1),       5'b10000);
    add("br_mem_alu_fwd",  mk(0, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 7, 0),       5'b00001);

    // reset
    cyc(idle_v, 1'b1, o);
    cyc(idle_v, 1'b1, o);
    cyc(idle_v, 1'b0, o);
    check5("reset_idle", o, 5'b00001);
    check32("reset_stall_cycles", bus.stall_cycles, 32'd0);
    check32("reset_flush_count", bus.flush_count, 32'd0);

    // single-cycle vectors, each leaves the controller in RUN
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].in, 1'b0, o);
      check5(tbl[i].name, o, tbl[i].exp);
    end

    // branch after load: two bubbles even though inputs change in the second cycle
    cyc(bl_v, 1'b0, o); check5("brld_c1", o, 5'b01100);
    cyc(tk_v, 1'b0, o); check5("brld_c2", o, 5'b01100);
    cyc(tk_v, 1'b0, o); check5("brld_flush", o, 5'b00011);

    // branch after ALU op: one bubble, then the taken branch flushes
    cyc(mk(3, 0, 1, 0, 1, 0, 1, 0, 1, 3, 0, 0, 0), 1'b0, o); check5("bralu_c1", o, 5'b01100);
    cyc(mk(3, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 3, 0), 1'b0, o); check5("bralu_flush", o, 5'b00011);

    // ext_stall for 3 cycles inside the branch wait freezes the countdown
    cyc(bl_v, 1'b0, o); check5("bwstall_enter", o, 5'b01100);
    for (int i = 0; i < 3; i++) begin
      cyc(stall_v, 1'b0, o); check5("bwstall_hold", o, 5'b10000);
    end
    cyc(tk_v, 1'b0, o); check5("bwstall_last_bubble", o, 5'b01100);
    cyc(tk_v, 1'b0, o); check5("bwstall_flush", o, 5'b00011);

    // reset while waiting; ext_stall alongside would otherwise keep BWAIT frozen
    cyc(bl_v, 1'b0, o); check5("bwrst_enter", o, 5'b01100);
    cyc(stall_v, 1'b1, o);
    cyc(idle_v, 1'b0, o); check5("bwrst_after", o, 5'b00001);
    check32("bwrst_stall_cycles", bus.stall_cycles, 32'd0);
    check32("bwrst_flush_count", bus.flush_count, 32'd0);

    // 2-bubble branch plus one flush
    cyc(bl_v, 1'b0, o);   check5("perf_b1", o, 5'b01100);
    cyc(idle_v, 1'b0, o); check5("perf_b2", o, 5'b01100);
    cyc(tk_v, 1'b0, o);   check5("perf_flush", o, 5'b00011);
    cyc(idle_v, 1'b0, o); check5("perf_idle", o, 5'b00001);
    check32("perf_stall_cycles", bus.stall_cycles, PERF_ON ? 32'd2 : 32'd0);
    check32("perf_flush_count", bus.flush_count, PERF_ON ? 32'd1 : 32'd0);

    // randomized run against the reference model
    cyc(idle_v, 1'b1, o);
    pend = 0; stall_m = 0; flush_m = 0;
    for (int n = 0; n < 3000; n++) begin
      rv = mk($urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1),
              ($urandom_range(0, 9) < 3) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
              $urandom_range(0, 1),
              ($urandom_range(0, 9) < 3) ? 1 : 0, $urandom_range(0, 1),
              $urandom_range(0, 3),
              ($urandom_range(0, 9) < 3) ? 1 : 0, $urandom_range(0, 3),
              ($urandom_range(0, 9) == 0) ? 1 : 0);
      r = ($urandom_range(0, 99) == 0);
      cyc(rv, r, o);
      check32("rand_stall_cycles", bus.stall_cycles, PERF_ON ? stall_m : 32'd0);
      check32("rand_flush_count", bus.flush_count, PERF_ON ? flush_m : 32'd0);
      e = ref_out(rv, pend, p_n);
      if (r) begin
        pend = 0; stall_m = 0; flush_m = 0;
      end else begin
        check5("rand_outputs", o, e);
        pend = p_n;
        if ((e[4] || e[3]) && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
        if (e[1] && flush_m != 32'hFFFF_FFFF) flush_m = flush_m + 1;
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Inspects the instruction in ID plus the destinations in EX and MEM, then sequences the IF/ID register's hold (hazard), hold-and-bubble (BranchBubble) and flush controls.
- Also drives PC write-enable and the ID/EX bubble.
- Owns a small FSM with a countdown so that multi-cycle branch-operand waits complete deterministically.

Parameters:
- REG_AW, 5, register-address width.
- MAX_BUB, 2, maximum consecutive branch bubbles (counter width = clog2(MAX_BUB+1)).
- PERF_W, 32, perf counter width (optional feature only).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_rs  in  REG_AW  ID source reg 1.
- id_rt  in  REG_AW  ID source reg 2.
- id_uses_rs  in  1  ID instruction reads rs.
- id_uses_rt  in  1  ID instruction reads rt.
- id_is_branch  in  1  ID is beq/bne/bgez/bgtz/blez/bltz/jalr (compares or reads regs in ID).
- id_is_jump  in  1  ID is j/jal.
- branch_taken  in  1  ID-stage resolution: branch taken this cycle (valid only when operands ready).
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes a register.
- ex_rd  in  REG_AW  EX destination.
- mem_mem_read  in  1  MEM instruction is a load.
- mem_rd  in  REG_AW  MEM destination.
- ext_stall  in  1  memory-system wait; freezes the whole front end.
- hazard  out  1  hold PC and IF/ID (load-use or ext_stall).
- branch_bubble  out  1  hold PC and IF/ID while a branch waits for operands.
- idex_bubble  out  1  load a NOP into ID/EX.
- if_flush  out  1  IF/ID loads zero instruction (taken branch/jump).
- pc_write  out  1  = !(hazard | branch_bubble).
- stall_cycles  out  PERF_W  perf counter (optional feature).
- flush_count  out  PERF_W  perf counter (optional feature).

Behaviour:
- Match definitions. A register matches when it is non-zero, equal to the destination, and its uses_* flag is set.
  - m_ex = (rs matches ex_rd) or (rt matches ex_rd).
  - m_mem = the same test against mem_rd.
- FSM states: RUN, BWAIT. Counter bcnt.
- Reset: state=RUN, bcnt=0. All outputs 0 except pc_write=1. Perf counters 0.
- Priority per cycle: ext_stall > load-use > branch wait > flush.
- ext_stall=1:
  - hazard=1, idex_bubble=0, if_flush=0.
  - State and bcnt frozen.
- RUN, load-use (ex_mem_read && m_ex && !id_is_branch):
  - hazard=1 and idex_bubble=1 for this cycle only (combinational).
  - No state change.
- RUN, branch dependency (id_is_branch):
  - need = 2 if (ex_mem_read && m_ex).
  - need = 1 if (ex_reg_write && m_ex) or (mem_mem_read && m_mem).
  - need = 0 otherwise.
  - need>0: branch_bubble=1 and idex_bubble=1 this cycle; go to BWAIT with bcnt=need-1. When need-1 = 0, stay RUN; the next cycle re-evaluates.
- BWAIT:
  - branch_bubble=1, idex_bubble=1. Inputs are not re-evaluated.
  - bcnt decrements each cycle.
  - Leave to RUN on the cycle bcnt==0 (that cycle still bubbles).
- RUN, no stall:
  - if_flush = (id_is_branch && branch_taken) || id_is_jump.
  - branch_taken is ignored whenever any stall/bubble is active.
- Outputs hazard/branch_bubble are never both 1. if_flush is never 1 with either.
- Reset asserted mid-BWAIT: next cycle state=RUN, bcnt=0, all stalls deasserted.
- bcnt never exceeds MAX_BUB-1. An unreachable state returns to RUN.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with hazard|branch_bubble.
  - flush_count increments on every if_flush.
  - Both saturate at all-ones and are cleared by rst.
- Undefined: both ports tied to 0 and no counter flops; interface unchanged.

Test Plan:
- After rst, idle inputs -> hazard=0, branch_bubble=0, if_flush=0, pc_write=1.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 -> hazard=1, idex_bubble=1, pc_write=0 for exactly 1 cycle. With ex_rd=0 -> no stall.
- Branch after load: id_is_branch=1, id_rt=8, ex_mem_read=1, ex_rd=8 -> branch_bubble=1 for 2 cycles, even if inputs change in cycle 2; then if_flush=1 when branch_taken=1.
- Branch after ALU op: ex_reg_write=1, ex_rd=3, id_rs=3 -> branch_bubble=1 for 1 cycle. Jump with no deps -> if_flush=1 for 1 cycle, pc_write=1.
- ext_stall=1 for 3 cycles during BWAIT (bcnt=1) -> hazard=1 for 3 cycles, bcnt held; afterwards 1 more bubble cycle.
- rst during BWAIT -> next cycle all stall/flush outputs 0. With HAZ_PERF_CNT_EN, a 2-bubble branch plus 1 flush -> stall_cycles=2, flush_count=1.
